// File: rtl/regfile_bank.sv
// regfile_bank: parametrised multi-read-port register file that clears itself
// with a one-entry-per-cycle sweep after reset so storage can map to RAM.
module regfile_bank #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD*DATA_W-1:0] ardata,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data,
  output logic                    busy,
  output logic                    wr_drop
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                  state_q;
  logic [ADDR_W-1:0]       ptr_q;
  logic [NREAD*DATA_W-1:0] rdata_q, rdata_d;
  logic                    wr_drop_q, wr_ok, mem_we;
  logic [ADDR_W-1:0]       mem_wa;
  logic [DATA_W-1:0]       mem_wd;
  logic [DATA_W-1:0]       mem_q [DEPTH];
  assign busy     = state_q == CLEAR;
  assign rdata    = rdata_q;
  assign wr_drop  = wr_drop_q;
  assign wr_ok    = !busy && we && !(ZERO_REG && waddr == '0);
  // single write port shared by the sweep and normal writes; nothing lands while reset is held
  assign mem_we   = !reset && (busy || wr_ok);
  assign mem_wa   = busy ? ptr_q : waddr;
  assign mem_wd   = busy ? '0 : wdata;
  assign dbg_data = ZERO_REG && dbg_addr == '0 ? '0 : mem_q[dbg_addr];
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero;
    assign ra   = raddr[k*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG && ra == '0;
    assign ardata[k*DATA_W +: DATA_W]  = zero ? '0 : mem_q[ra];
    assign rdata_d[k*DATA_W +: DATA_W] = busy || zero ? '0 :
                                         BYPASS && wr_ok && waddr == ra ? wdata : mem_q[ra];
  end
  always_ff @(posedge clock)
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CLEAR;
      ptr_q     <= '0;
      rdata_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      ptr_q     <= busy ? ptr_q + 1'b1 : ptr_q;
      if (busy && &ptr_q) state_q <= RUN;
      rdata_q   <= rdata_d;
      wr_drop_q <= busy && we;
    end
  end
endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: four regfile_bank configurations driven by one shared
// stimulus stream and checked against an array-based reference model.
module tb_regfile_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst, we;
  logic [4:0]  ra [4];
  logic [4:0]  wa, dbg;
  logic [31:0] wd;
  logic [9:0]  raddr_w;
  logic [11:0] raddr_n;
  logic [63:0] rd0, rd1, rd2, ard0, ard1, ard2;
  logic [63:0] rd3, ard3;
  logic [31:0] dbg0, dbg1, dbg2;
  logic [15:0] dbg3;
  logic        bsy [4];
  logic        drp [4];
  assign raddr_w = {ra[1], ra[0]};
  assign raddr_n = {ra[3][2:0], ra[2][2:0], ra[1][2:0], ra[0][2:0]};
  regfile_bank u0 (.clock(clk), .reset(rst), .raddr(raddr_w), .rdata(rd0), .ardata(ard0),
    .we(we), .waddr(wa), .wdata(wd), .dbg_addr(dbg), .dbg_data(dbg0), .busy(bsy[0]), .wr_drop(drp[0]));
  regfile_bank #(.BYPASS(1'b0)) u1 (.clock(clk), .reset(rst), .raddr(raddr_w), .rdata(rd1), .ardata(ard1),
    .we(we), .waddr(wa), .wdata(wd), .dbg_addr(dbg), .dbg_data(dbg1), .busy(bsy[1]), .wr_drop(drp[1]));
  regfile_bank #(.ZERO_REG(1'b0)) u2 (.clock(clk), .reset(rst), .raddr(raddr_w), .rdata(rd2), .ardata(ard2),
    .we(we), .waddr(wa), .wdata(wd), .dbg_addr(dbg), .dbg_data(dbg2), .busy(bsy[2]), .wr_drop(drp[2]));
  regfile_bank #(.DATA_W(16), .ADDR_W(3), .NREAD(4)) u3 (.clock(clk), .reset(rst), .raddr(raddr_n),
    .rdata(rd3), .ardata(ard3), .we(we), .waddr(wa[2:0]), .wdata(wd[15:0]), .dbg_addr(dbg[2:0]),
    .dbg_data(dbg3), .busy(bsy[3]), .wr_drop(drp[3]));
  int aw [4] = '{5, 5, 5, 3};
  int nr [4] = '{2, 2, 2, 4};
  bit zr [4] = '{1, 1, 0, 1};
  bit bp [4] = '{1, 0, 1, 1};
  logic [31:0] m [4][32];
  bit          kn [4][32];
  int          cnt [4];
  logic [31:0] erd [4][4];
  bit          ekn [4][4];
  bit          edrop [4];
  int n_chk = 0, n_bad = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] dmask(int c);
    return c == 3 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic int amask(int c);
    return (1 << aw[c]) - 1;
  endfunction
  function automatic logic [31:0] g_rd(int c, int k);
    case (c)
      0: return rd0[k*32 +: 32];
      1: return rd1[k*32 +: 32];
      2: return rd2[k*32 +: 32];
      default: return {16'h0, rd3[k*16 +: 16]};
    endcase
  endfunction
  function automatic logic [31:0] g_ard(int c, int k);
    case (c)
      0: return ard0[k*32 +: 32];
      1: return ard1[k*32 +: 32];
      2: return ard2[k*32 +: 32];
      default: return {16'h0, ard3[k*16 +: 16]};
    endcase
  endfunction
  function automatic logic [31:0] g_dbg(int c);
    return c == 0 ? dbg0 : c == 1 ? dbg1 : c == 2 ? dbg2 : {16'h0, dbg3};
  endfunction
  task automatic model_edge();
    for (int c = 0; c < 4; c++) begin
      int depth = 1 << aw[c];
      if (rst) begin
        cnt[c] = depth;
        edrop[c] = 1'b0;
        for (int k = 0; k < 4; k++) begin erd[c][k] = '0; ekn[c][k] = 1'b1; end
      end else if (cnt[c] > 0) begin
        m[c][depth - cnt[c]] = '0;
        kn[c][depth - cnt[c]] = 1'b1;
        cnt[c]--;
        edrop[c] = we;
        for (int k = 0; k < 4; k++) begin erd[c][k] = '0; ekn[c][k] = 1'b1; end
      end else begin
        int w = int'(wa) & amask(c);
        bit ok = we && !(zr[c] && w == 0);
        for (int k = 0; k < nr[c]; k++) begin
          int a = int'(ra[k]) & amask(c);
          if (zr[c] && a == 0) begin erd[c][k] = '0; ekn[c][k] = 1'b1; end
          else if (bp[c] && ok && w == a) begin erd[c][k] = wd & dmask(c); ekn[c][k] = 1'b1; end
          else begin erd[c][k] = m[c][a]; ekn[c][k] = kn[c][a]; end
        end
        if (ok) begin m[c][w] = wd & dmask(c); kn[c][w] = 1'b1; end
        edrop[c] = 1'b0;
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      int d = int'(dbg) & amask(c);
      for (int k = 0; k < nr[c]; k++) begin
        int a = int'(ra[k]) & amask(c);
        if (zr[c] && a == 0) chk($sformatf("ardata c%0d p%0d", c, k), g_ard(c, k), '0);
        else if (kn[c][a]) chk($sformatf("ardata c%0d p%0d", c, k), g_ard(c, k), m[c][a]);
      end
      if (zr[c] && d == 0) chk($sformatf("dbg c%0d", c), g_dbg(c), '0);
      else if (kn[c][d]) chk($sformatf("dbg c%0d", c), g_dbg(c), m[c][d]);
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("busy c%0d", c), {31'b0, bsy[c]}, {31'b0, cnt[c] > 0});
      chk($sformatf("wr_drop c%0d", c), {31'b0, drp[c]}, {31'b0, edrop[c]});
      for (int k = 0; k < nr[c]; k++)
        if (ekn[c][k]) chk($sformatf("rdata c%0d p%0d", c, k), g_rd(c, k), erd[c][k]);
    end
  endtask
  task automatic rnd();
    for (int k = 0; k < 4; k++) ra[k] = 5'($urandom_range(0, 31));
    we  = 1'($urandom);
    wa  = 5'($urandom_range(0, 31));
    wd  = $urandom;
    dbg = 5'($urandom_range(0, 31));
  endtask
  task automatic wr(int a, logic [31:0] v);
    we = 1'b1; wa = 5'(a); wd = v;
    tick();
    we = 1'b0;
  endtask
  initial begin
    for (int c = 0; c < 4; c++) begin
      cnt[c] = 0;
      edrop[c] = 1'b0;
      for (int i = 0; i < 32; i++) kn[c][i] = 1'b0;
      for (int k = 0; k < 4; k++) ekn[c][k] = 1'b0;
    end
    rst = 1'b1;
    rnd();
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rnd();
      if (i == 5) begin we = 1'b1; wa = 5'd20; end
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 4; k++) ra[k] = 5'($urandom_range(0, 31));
      dbg = 5'(i);
      tick();
    end
    wr(7, 32'hDEAD_BEEF);
    ra[0] = 5'd7;
    repeat (2) tick();
    wr(3, 32'h1111_1111);
    ra[1] = 5'd3;
    wr(3, 32'h2222_2222);
    tick();
    ra[0] = 5'd0;
    wr(0, 32'hFFFF_FFFF);
    dbg = 5'd0;
    tick();
    wr(5, 32'h0000_A5A5);
    for (int k = 0; k < 4; k++) ra[k] = 5'd5;
    repeat (2) tick();
    for (int i = 1; i < 5; i++) wr(i + 8, 32'h1111 * i);
    for (int k = 0; k < 4; k++) ra[k] = 5'(k + 9);
    repeat (2) tick();
    for (int i = 0; i < 400; i++) begin
      rnd();
      rst = $urandom_range(0, 63) == 0;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) begin rnd(); tick(); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (40) begin rnd(); tick(); end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
- Parametrised multi-read-port register file for the datapath; next generation of the 32x32 two-read/one-write bank.
- Configurable data width, depth and read-port count.
- Optional hardwired zero register and write-to-read bypass.
- Clears itself with a synchronous sweep after reset instead of a one-cycle parallel clear, so it maps to RAM-style storage. A busy flag gates use during the sweep.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NREAD, 2, number of read ports (1..4)
ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded
BYPASS, 1, when 1 registered reads forward same-cycle write data (write-first)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
raddr  in  NREAD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
rdata  out  NREAD*DATA_W  registered read data, 1-cycle latency, packed like raddr
ardata  out  NREAD*DATA_W  combinational read of storage (no bypass), packed
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
dbg_addr  in  ADDR_W  debug tap address
dbg_data  out  DATA_W  combinational storage read at dbg_addr (ZERO_REG rule applies)
busy  out  1  high while clear sweep in progress
wr_drop  out  1  registered 1-cycle pulse: a write was discarded because busy

Behaviour:
- States:
  - CLEAR: sweep pointer ptr[ADDR_W-1:0].
  - RUN: normal operation.
- Reset (sampled at edge with reset=1):
  - state<=CLEAR, ptr<=0, busy<=1, rdata<=0, wr_drop<=0.
  - Storage is not cleared in that cycle.
- Sweep:
  - Each edge in CLEAR with reset=0 writes 0 to entry ptr, then ptr<=ptr+1.
  - On the edge that writes entry DEPTH-1, state<=RUN and busy<=0.
  - busy is therefore high for exactly DEPTH cycles after reset deasserts.
  - Reset held high keeps ptr at 0.
  - Reset reasserted mid-sweep or mid-RUN restarts the sweep from 0.
- While busy:
  - we is ignored; storage is touched only by the sweep.
  - If we=1, wr_drop pulses on the next cycle.
  - rdata<=0 each edge.
  - ardata and dbg_data show raw storage, including partially cleared contents.
- RUN write: on an edge with we=1, mem[waddr]<=wdata. Exception: ZERO_REG=1 and waddr=0, where the write is discarded silently with no wr_drop.
- RUN registered read: rdata[k] <= value at raddr[k], resolved in this priority:
  1. ZERO_REG=1 and raddr[k]=0 -> 0.
  2. BYPASS=1, we=1, waddr=raddr[k] and write not discarded -> wdata.
  3. Otherwise -> old mem[raddr[k]].
  - With BYPASS=0, same-address same-cycle reads return the old value.
- ardata[k]: combinational mem[raddr[k]], 0 for address 0 when ZERO_REG=1. Never forwards wdata.
- Ports are independent: all NREAD ports may address the same entry with identical results.
- No arithmetic; addresses are used unmodified, since DEPTH is an exact power of two and no out-of-range address exists.

Test Plan:
- Reset clear, default params, stale storage:
  - Hold reset 3 cycles, release.
  - busy=1 for exactly 32 cycles, then 0.
  - Every dbg_data sweep of 0..31 reads 0x00000000.
- Write/read with latency:
  - After clear, write 0xDEADBEEF to 7.
  - Next cycle raddr0=7 -> ardata0=0xDEADBEEF the same cycle; rdata0=0xDEADBEEF one cycle later.
- Bypass vs no bypass:
  - Entry 3 holds 0x11111111; write 0x22222222 to 3 while raddr1=3.
  - BYPASS=1 -> next rdata1=0x22222222; BYPASS=0 -> 0x11111111.
  - ardata1 shows 0x11111111 in that cycle in both cases.
- Zero register:
  - Write 0xFFFFFFFF to 0 with raddr0=0.
  - ZERO_REG=1 -> rdata0=0, dbg_data(0)=0, wr_drop=0.
  - ZERO_REG=0 -> rdata0=0xFFFFFFFF via bypass.
- Write during sweep and mid-sweep reset:
  - we=1 to addr 20 at sweep cycle 5 -> wr_drop pulses 1 cycle and entry 20 reads 0 afterwards.
  - Reassert reset at sweep cycle 10 -> busy stays high 32 further cycles after release.
- Parameter sweep DATA_W=16, ADDR_W=3, NREAD=4:
  - busy lasts 8 cycles.
  - All four ports reading the same entry 5 (0xA5A5) return 0xA5A5.
  - Distinct addresses return their own values.
